sequencial_message_passer: RTL and testbench
============================================

# sequencial_message_passer

Per-pixel message-update engine for the TRW-S stereo/labelling pipeline. For one pixel it takes the unary data cost and the four incoming neighbour messages, all label-parallel. The data cost and forward messages arrive on one beat; the backward messages arrive on the next beat. It produces the outgoing forward messages to the right and lower neighbours, using gamma = 1/2 reweighting, a Potts smoothness term and min-normalisation.

## Interface
- LABELS, default 16: number of labels per vector.
- MESSAGE_WIDTH, default 6: unsigned bits per message element.
- DATA_WIDTH, default 8: unsigned bits per data-cost element.
- SMOOTH_COST, default 8: Potts penalty lambda, must be ≤ 2^MESSAGE_WIDTH−1 (4th parameter).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- horizontal_message_forward  in  LABELS*MESSAGE_WIDTH  message from left neighbour; valid on push beat.
- horizontal_message_backward  in  LABELS*MESSAGE_WIDTH  message from right neighbour; valid on beat after push.
- vertical_message_forward  in  LABELS*MESSAGE_WIDTH  message from upper neighbour; push beat.
- vertical_message_backward  in  LABELS*MESSAGE_WIDTH  message from lower neighbour; beat after push.
- data  in  LABELS*DATA_WIDTH  unary cost; push beat.
- push  in  1  marks the first beat of a pixel.
- valid  out  1  one-cycle pulse, outputs hold a new result.
- horizontal_out  out  LABELS*MESSAGE_WIDTH  message to right neighbour.
- vertical_out  out  LABELS*MESSAGE_WIDTH  message to lower neighbour.

Packing: label l occupies bits [(l+1)*W−1 : l*W].

## Operation
- Belief: b[l] = data[l] + hf[l] + hb[l] + vf[l] + vb[l], unsigned, width max(DATA_WIDTH,MESSAGE_WIDTH)+3, no overflow.
- Horizontal pre-message: hh[l] = (b[l] >> 1) − hb[l], signed (one extra bit).
- Vertical pre-message: hv[l] = (b[l] >> 1) − vb[l], signed (one extra bit).
- Minimum: hmin_h = min over l of hh, and hmin_v = min over l of hv.
- Output: horizontal_out[l] = min(hh[l] − hmin_h, SMOOTH_COST). This is the Potts min-convolution, already normalised so the minimum element is 0.
- vertical_out is computed the same way from hv and hmin_v.
- Results are always in 0..SMOOTH_COST, so no further saturation is needed.
- Outputs hold their last value until the next valid.

## Timing
- Edge E0, push=1: register data, hf and vf.
- Edge E1, the next edge: register hb and vb unconditionally; push is ignored at E1.
- Edge E2: register hh and hv for all labels.
- Edge E3: register hmin_h and hmin_v.
- Edge E4: register outputs and set valid=1.
- valid is high for exactly the cycle after E4 and is cleared at E5 unless another result completes.
- Fully pipelined: a new push is accepted every 2 cycles, i.e. at E2 at the earliest. Results emerge in order, 4 edges after their push.
- push held high continuously: pixels are taken on alternate edges (E0, E2, E4…).
- Reset: valid=0, all outputs 0, all pipeline valid bits and beat-phase state cleared. Reset mid-operation discards in-flight pixels. The first push after reset deassertion is treated as beat 0.

## Structure
- Package holds width helpers (belief width, signed pre-message width) and the beat-phase encoding.
- One natural sub-module, `message_direction_unit`, instantiated twice (horizontal and vertical). It takes the belief vector and the opposite incoming message and produces the normalised Potts output, covering pipeline stages E2–E4.
- The top level holds beat capture, belief summation and the valid pipeline.

## Test plan
- Defaults (LABELS=16, MW=6, DW=8, lambda=8): push with data=1 and hf=vf=l+1, except vf[1]=32; next beat hb=vb=l+1. Required response 4 edges after push, valid=1 for one cycle:
  - horizontal_out = vertical_out = [0,8,2,3,4,5,6,7,8,8,8,8,8,8,8,8].
- All inputs zero, push once -> valid pulses once with both outputs all zero.
- data[5]=0 and data[l]=40 elsewhere, all messages 0 -> out[5]=0 and out[l]=8 for every other l, in both directions.
- push high for 4 consecutive cycles with distinct pixels on E0 and E2 -> two valid pulses at E4 and E6; each result matches its own pixel, and the E1 and E3 pushes are ignored.
- Assert rst at E2, between beat 1 and output -> valid never rises, outputs 0. A fresh push after release yields a normal result at +4 edges.
- All messages at max (63) and data max (255) -> no overflow, out all zero.

Source files
------------

// File: rtl/sequencial_message_passer_pkg.sv
// Shared width helpers and beat-phase encoding for the per-pixel TRW-S
// message-update engine.
package sequencial_message_passer_pkg;

  typedef enum logic {
    PH_BEAT0 = 1'b0,
    PH_BEAT1 = 1'b1
  } phase_e;

  // Sum of one data cost and four messages needs three carry bits on top
  // of the widest operand.
  function automatic int belief_width(input int dw, input int mw);
    return ((dw > mw) ? dw : mw) + 3;
  endfunction

  function automatic int pre_width(input int dw, input int mw);
    return belief_width(dw, mw) + 1;
  endfunction

endpackage

// File: rtl/sequencial_message_passer_direction.sv
// One outgoing direction: gamma=1/2 reweighting, min search and Potts
// min-convolution with normalisation, registered over three stages.
module message_direction_unit #(
  parameter int LABELS        = 16,
  parameter int MESSAGE_WIDTH = 6,
  parameter int BELIEF_WIDTH  = 11,
  parameter int SMOOTH_COST   = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load_pre,
  input  logic                                     load_min,
  input  logic                                     load_out,
  input  logic [LABELS-1:0][BELIEF_WIDTH-1:0]      belief,
  input  logic [LABELS-1:0][MESSAGE_WIDTH-1:0]     opposite,
  output logic [LABELS-1:0][MESSAGE_WIDTH-1:0]     msg_out
);

  localparam int PW = BELIEF_WIDTH + 1;

  logic [LABELS-1:0][PW-1:0]            pre_q, pre_d;
  logic [PW-1:0]                        min_q, min_d;
  logic [LABELS-1:0][MESSAGE_WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]                        run_min;
  logic [PW-1:0]                        diff;

  // Two's-complement subtraction in PW bits gives the signed pre-message.
  always_comb begin
    pre_d = pre_q;
    if (load_pre) begin
      for (int l = 0; l < LABELS; l++) begin
        pre_d[l] = PW'(belief[l] >> 1) - PW'(opposite[l]);
      end
    end
  end

  always_comb begin
    run_min = pre_q[0];
    for (int l = 1; l < LABELS; l++) begin
      if ($signed(pre_q[l]) < $signed(run_min)) run_min = pre_q[l];
    end
    min_d = load_min ? run_min : min_q;
  end

  // Difference to the minimum is non-negative, so an unsigned clamp suffices.
  always_comb begin
    out_d = out_q;
    diff  = '0;
    if (load_out) begin
      for (int l = 0; l < LABELS; l++) begin
        diff     = pre_q[l] - min_q;
        out_d[l] = (diff > PW'(SMOOTH_COST)) ? MESSAGE_WIDTH'(SMOOTH_COST)
                                             : diff[MESSAGE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      min_q <= '0;
      out_q <= '0;
    end else begin
      pre_q <= pre_d;
      min_q <= min_d;
      out_q <= out_d;
    end
  end

  assign msg_out = out_q;

endmodule

// File: rtl/sequencial_message_passer.sv
// Two-beat pixel capture, belief summation and valid pipeline feeding the
// horizontal and vertical direction units.
module sequencial_message_passer
  import sequencial_message_passer_pkg::*;
#(
  parameter int LABELS        = 16,
  parameter int MESSAGE_WIDTH = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int SMOOTH_COST   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_message_forward,
  input  logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_message_backward,
  input  logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_message_forward,
  input  logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_message_backward,
  input  logic [LABELS*DATA_WIDTH-1:0]      data,
  input  logic                              push,
  output logic                              valid,
  output logic [LABELS*MESSAGE_WIDTH-1:0]   horizontal_out,
  output logic [LABELS*MESSAGE_WIDTH-1:0]   vertical_out
);

  localparam int BW = belief_width(DATA_WIDTH, MESSAGE_WIDTH);

  phase_e phase_q, phase_d;
  logic   capture_fwd, capture_bwd;

  logic [LABELS-1:0][DATA_WIDTH-1:0]    data_q, data_d;
  logic [LABELS-1:0][MESSAGE_WIDTH-1:0] hf_q, hf_d, vf_q, vf_d;
  logic [LABELS-1:0][MESSAGE_WIDTH-1:0] hb_q, hb_d, vb_q, vb_d;
  logic                                 s1_vld_q, s1_vld_d;
  logic                                 s2_vld_q, s2_vld_d;
  logic                                 s3_vld_q, s3_vld_d;
  logic                                 valid_q, valid_d;
  logic [LABELS-1:0][BW-1:0]            belief;
  logic [LABELS-1:0][MESSAGE_WIDTH-1:0] h_msg, v_msg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= PH_BEAT0;
    else     phase_q <= phase_d;
  end

  // Beat 1 always follows a push; push is ignored while in beat 1.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_BEAT0: if (push) phase_d = PH_BEAT1;
      PH_BEAT1: phase_d = PH_BEAT0;
      default:  phase_d = PH_BEAT0;
    endcase
  end

  always_comb begin
    capture_fwd = (phase_q == PH_BEAT0) && push;
    capture_bwd = (phase_q == PH_BEAT1);
  end

  always_comb begin
    data_d   = capture_fwd ? data                        : data_q;
    hf_d     = capture_fwd ? horizontal_message_forward  : hf_q;
    vf_d     = capture_fwd ? vertical_message_forward    : vf_q;
    hb_d     = capture_bwd ? horizontal_message_backward : hb_q;
    vb_d     = capture_bwd ? vertical_message_backward   : vb_q;
    s1_vld_d = capture_bwd;
    s2_vld_d = s1_vld_q;
    s3_vld_d = s2_vld_q;
    valid_d  = s3_vld_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      hf_q     <= '0;
      vf_q     <= '0;
      hb_q     <= '0;
      vb_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      data_q   <= data_d;
      hf_q     <= hf_d;
      vf_q     <= vf_d;
      hb_q     <= hb_d;
      vb_q     <= vb_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    for (int l = 0; l < LABELS; l++) begin
      belief[l] = BW'(data_q[l]) + BW'(hf_q[l]) + BW'(hb_q[l])
                + BW'(vf_q[l]) + BW'(vb_q[l]);
    end
  end

  message_direction_unit #(
    .LABELS(LABELS), .MESSAGE_WIDTH(MESSAGE_WIDTH),
    .BELIEF_WIDTH(BW), .SMOOTH_COST(SMOOTH_COST)
  ) u_horizontal (
    .clk(clk), .rst(rst),
    .load_pre(s1_vld_q), .load_min(s2_vld_q), .load_out(s3_vld_q),
    .belief(belief), .opposite(hb_q), .msg_out(h_msg)
  );

  message_direction_unit #(
    .LABELS(LABELS), .MESSAGE_WIDTH(MESSAGE_WIDTH),
    .BELIEF_WIDTH(BW), .SMOOTH_COST(SMOOTH_COST)
  ) u_vertical (
    .clk(clk), .rst(rst),
    .load_pre(s1_vld_q), .load_min(s2_vld_q), .load_out(s3_vld_q),
    .belief(belief), .opposite(vb_q), .msg_out(v_msg)
  );

  assign valid          = valid_q;
  assign horizontal_out = h_msg;
  assign vertical_out   = v_msg;

endmodule

// File: tb/tb_sequencial_message_passer.sv
// Directed and randomized checks of the message-update engine against an
// integer reference model of the belief/Potts update.
module tb_sequencial_message_passer;

  localparam int L  = 16;
  localparam int MW = 6;
  localparam int DW = 8;
  localparam int SC = 8;
  localparam int VW = L * MW;
  localparam int DV = L * DW;
  localparam int CW = 2 * VW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] hf = '0, hb = '0, vf = '0, vb = '0;
  logic [DV-1:0] data = '0;
  logic          push = 1'b0;
  logic          valid;
  logic [VW-1:0] horizontal_out, vertical_out;

  logic [DV-1:0] d_v;
  logic [VW-1:0] hf_v, hb_v, vf_v, vb_v;
  logic [CW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  sequencial_message_passer #(
    .LABELS(L), .MESSAGE_WIDTH(MW), .DATA_WIDTH(DW), .SMOOTH_COST(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .horizontal_message_forward(hf), .horizontal_message_backward(hb),
    .vertical_message_forward(vf), .vertical_message_backward(vb),
    .data(data), .push(push), .valid(valid),
    .horizontal_out(horizontal_out), .vertical_out(vertical_out)
  );

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: integer belief, halved, minus the opposite message, normalised, clamped.
  function automatic logic [VW-1:0] model(input logic [DV-1:0] d, input logic [VW-1:0] mhf,
      input logic [VW-1:0] mhb, input logic [VW-1:0] mvf, input logic [VW-1:0] mvb, input bit vert);
    int pre[L];
    int b, mn, o;
    logic [VW-1:0] r;
    for (int l = 0; l < L; l++) begin
      b = int'(d[l*DW +: DW]) + int'(mhf[l*MW +: MW]) + int'(mhb[l*MW +: MW])
        + int'(mvf[l*MW +: MW]) + int'(mvb[l*MW +: MW]);
      pre[l] = b / 2 - (vert ? int'(mvb[l*MW +: MW]) : int'(mhb[l*MW +: MW]));
    end
    mn = pre[0];
    for (int l = 1; l < L; l++) if (pre[l] < mn) mn = pre[l];
    r = '0;
    for (int l = 0; l < L; l++) begin
      o = pre[l] - mn;
      if (o > SC) o = SC;
      r[l*MW +: MW] = MW'(o);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] junk_msg();
    logic [VW-1:0] r;
    for (int l = 0; l < L; l++) r[l*MW +: MW] = MW'($urandom_range(0, 63));
    return r;
  endfunction

  function automatic logic [DV-1:0] junk_data();
    logic [DV-1:0] r;
    for (int l = 0; l < L; l++) r[l*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic rand_pixel();
    int mode, dmax, mmax;
    mode = $urandom_range(0, 2);
    dmax = (mode == 0) ? 255 : (mode == 1) ? 30 : 60;
    mmax = (mode == 1) ? 10 : 63;
    for (int l = 0; l < L; l++) begin
      d_v[l*DW +: DW]  = DW'($urandom_range(0, dmax));
      hf_v[l*MW +: MW] = MW'($urandom_range(0, mmax));
      hb_v[l*MW +: MW] = MW'($urandom_range(0, mmax));
      vf_v[l*MW +: MW] = MW'($urandom_range(0, mmax));
      vb_v[l*MW +: MW] = MW'($urandom_range(0, mmax));
    end
  endtask

  task automatic set_uniform(input int dval, input int mval);
    for (int l = 0; l < L; l++) begin
      d_v[l*DW +: DW]  = DW'(dval);
      hf_v[l*MW +: MW] = MW'(mval);
      hb_v[l*MW +: MW] = MW'(mval);
      vf_v[l*MW +: MW] = MW'(mval);
      vb_v[l*MW +: MW] = MW'(mval);
    end
  endtask

  // Forward beat then backward beat; idle ports carry random junk.
  task automatic drive_pixel(input bit keep_push);
    @(negedge clk);
    push = 1'b1; data = d_v; hf = hf_v; vf = vf_v; hb = junk_msg(); vb = junk_msg();
    @(negedge clk);
    push = keep_push; data = junk_data(); hf = junk_msg(); vf = junk_msg(); hb = hb_v; vb = vb_v;
    exp_q.push_back({model(d_v, hf_v, hb_v, vf_v, vb_v, 1'b0), model(d_v, hf_v, hb_v, vf_v, vb_v, 1'b1)});
  endtask

  task automatic run_single(input string tag);
    logic [CW-1:0] expv;
    int n;
    drive_pixel(1'b0);
    expv = exp_q.pop_front();
    @(negedge clk);
    n = 1;
    while (!valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, CW'(n), CW'(4));
    check({tag, "_out"}, {horizontal_out, vertical_out}, expv);
    @(negedge clk);
    check({tag, "_pulse"}, CW'(valid), CW'(0));
    check({tag, "_hold"}, {horizontal_out, vertical_out}, expv);
  endtask

  task automatic run_pair(input string tag);
    logic [CW-1:0] exp_a, exp_b;
    rand_pixel();
    drive_pixel(1'b1);
    rand_pixel();
    drive_pixel(1'b1);
    exp_a = exp_q.pop_front();
    exp_b = exp_q.pop_front();
    @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    check({tag, "_a_valid"}, CW'(valid), CW'(1));
    check({tag, "_a_out"}, {horizontal_out, vertical_out}, exp_a);
    @(negedge clk);
    check({tag, "_gap"}, CW'(valid), CW'(0));
    @(negedge clk);
    check({tag, "_b_valid"}, CW'(valid), CW'(1));
    check({tag, "_b_out"}, {horizontal_out, vertical_out}, exp_b);
  endtask

  initial begin
    bit seen;

    repeat (3) @(negedge clk);
    check("reset_valid", CW'(valid), CW'(0));
    check("reset_out", {horizontal_out, vertical_out}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Reference vector with a large vertical forward message on label 1.
    for (int l = 0; l < L; l++) begin
      d_v[l*DW +: DW]  = DW'(1);
      hf_v[l*MW +: MW] = MW'(l + 1);
      vf_v[l*MW +: MW] = MW'(l + 1);
      hb_v[l*MW +: MW] = MW'(l + 1);
      vb_v[l*MW +: MW] = MW'(l + 1);
    end
    vf_v[1*MW +: MW] = MW'(32);
    run_single("ref_vec");
    check("ref_vec_h_lit", CW'(horizontal_out),
          CW'({6'd8, 6'd8, 6'd8, 6'd8, 6'd8, 6'd8, 6'd8, 6'd8,
               6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd8, 6'd0}));

    set_uniform(0, 0);
    run_single("zeros");

    set_uniform(40, 0);
    d_v[5*DW +: DW] = '0;
    run_single("data5");

    set_uniform(255, 63);
    run_single("max");

    // Reset after the backward beat, before the result completes.
    rand_pixel();
    run_single("pre_rst");
    rand_pixel();
    drive_pixel(1'b0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_out", {horizontal_out, vertical_out}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check("rst_no_valid", CW'(seen), CW'(0));
    check("rst_out_zero", {horizontal_out, vertical_out}, '0);
    rand_pixel();
    run_single("after_rst");

    for (int i = 0; i < 6; i++) run_pair($sformatf("pair%0d", i));
    for (int i = 0; i < 20; i++) begin
      rand_pixel();
      run_single($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
